// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: AXI4 AW/W/B/AR/R bundle between a burst master and a slave
// master modport drives valids/payloads and B/R readies; slave modport is the mirror image.
interface axi_burst_master_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;
  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bresp, bid, output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input rvalid, rresp, rdata, rlast, rid, output rready
  );
  modport slave (
    input awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready,
    input arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rresp, rdata, rlast, rid, input rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// axi_burst_master: turns one client request into a single AXI4 INCR read or write burst
// Ports: clk/rst; req_* request handshake; wd_* write beats from client; rd_* read beats to client;
// resp_valid/resp_err one-cycle completion; axi = AXI4 master side of axi_burst_master_if.
module axi_burst_master #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [2:0]  req_size,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [31:0] wd_data,
  input  logic [3:0]  wd_strb,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        resp_valid,
  output logic        resp_err,
  axi_burst_master_if.master axi
);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;
  state_t      state, next;
  logic [31:0] addr;
  logic [7:0]  len, cnt;
  logic [2:0]  size;
  logic        err, err_n, req_hs, r_hs, w_hs, b_hs, at_last, done;
  logic        unused;
  assign unused  = ^{axi.bid, axi.rid};
  assign at_last = cnt == len;
  assign req_hs  = req_valid & req_ready;
  assign r_hs    = (state == R) & axi.rvalid & rd_ready;
  assign w_hs    = (state == W) & wd_valid & axi.wready;
  assign b_hs    = (state == B) & axi.bvalid;
  assign done    = (r_hs & axi.rlast) | b_hs;
  // rlast must coincide with the len-th beat; a mismatch either way flags the burst
  assign err_n   = err | (r_hs & ((axi.rresp != 2'b00) | (axi.rlast != at_last)))
                 | (b_hs & (axi.bresp != 2'b00));
  always_comb begin
    next        = state;
    req_ready   = (state == IDLE) & ~rst;
    axi.arvalid = state == AR;
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arsize  = size;
    axi.arburst = 2'b01;
    axi.arid    = AXI_ID;
    axi.awvalid = state == AW;
    axi.awaddr  = addr;
    axi.awlen   = len;
    axi.awsize  = size;
    axi.awburst = 2'b01;
    axi.awid    = AXI_ID;
    rd_valid    = (state == R) & axi.rvalid;
    axi.rready  = (state == R) & rd_ready;
    rd_data     = axi.rdata;
    rd_last     = axi.rlast;
    axi.wvalid  = (state == W) & wd_valid;
    wd_ready    = (state == W) & axi.wready;
    axi.wdata   = wd_data;
    axi.wstrb   = wd_strb;
    axi.wlast   = (state == W) & at_last;
    axi.bready  = state == B;
    case (state)
      IDLE:    next = req_valid ? (req_write ? AW : AR) : IDLE;
      AR:      next = axi.arready ? R : AR;
      R:       next = (r_hs & axi.rlast) ? IDLE : R;
      AW:      next = axi.awready ? W : AW;
      W:       next = (w_hs & at_last) ? B : W;
      B:       next = axi.bvalid ? IDLE : B;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      err        <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      state      <= next;
      cnt        <= req_hs ? 8'd0 : cnt + {7'd0, r_hs | w_hs};
      err        <= req_hs ? 1'b0 : err_n;
      resp_valid <= done;
      resp_err   <= done & err_n;
    end
  end
  always_ff @(posedge clk) begin
    if (req_hs) begin
      addr <= req_addr;
      len  <= req_len;
      size <= req_size;
    end
  end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed self-checking bench for axi_burst_master with a scripted AXI slave
module tb_axi_burst_master;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [2:0]  req_size = 3'd2;
  logic        wd_valid = 1'b0, rd_ready = 1'b0;
  logic [31:0] wd_data = '0;
  logic [3:0]  wd_strb = 4'hF;
  logic        req_ready, wd_ready, rd_valid, rd_last, resp_valid, resp_err;
  logic [31:0] rd_data;
  int          tests = 0, fails = 0;
  axi_burst_master_if axi();
  axi_burst_master #(.AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .axi(axi)
  );
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic w, input logic [31:0] a, input logic [7:0] l);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_size = 3'd2;
    step;
    req_valid = 1'b0;
  endtask

  task automatic ar_hs;
    axi.arready = 1'b1;
    step;
    axi.arready = 1'b0;
  endtask

  task automatic aw_hs;
    axi.awready = 1'b1;
    step;
    axi.awready = 1'b0;
  endtask

  task automatic test_reset;
    step; step; #1;
    tests++; if ({req_ready, resp_valid, resp_err, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, rd_valid, wd_ready} !== 10'b0) begin
      fails++; $display("FAIL reset_outputs: got %b want 0", {req_ready, resp_valid, resp_err, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, rd_valid, wd_ready});
    end
    rst = 1'b0; #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single_read;
    send_req(1'b0, 32'h8000_0000, 8'd0); #1;
    tests++; if ({axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid, req_ready} !== {1'b1, 32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd0, 1'b0}) begin
      fails++; $display("FAIL single_ar_fields: got %h want %h", {axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid, req_ready}, {1'b1, 32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd0, 1'b0});
    end
    ar_hs; #1;
    tests++; if ({axi.arvalid, rd_valid} !== 2'b00) begin fails++; $display("FAIL single_after_ar: got %b want 00", {axi.arvalid, rd_valid}); end
    step;
    axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF; axi.rlast = 1'b1; axi.rresp = 2'b00; rd_ready = 1'b1; #1;
    tests++; if ({rd_valid, rd_data, rd_last, axi.rready} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
      fails++; $display("FAIL single_r_beat: got %h want %h", {rd_valid, rd_data, rd_last, axi.rready}, {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1});
    end
    step;
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_ready = 1'b0; #1;
    tests++; if ({resp_valid, resp_err, req_ready} !== 3'b101) begin fails++; $display("FAIL single_resp: got %b want 101", {resp_valid, resp_err, req_ready}); end
    step;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL single_resp_pulse: got %b want 0", resp_valid); end
  endtask

  task automatic test_read_backpressure;
    int beat = 0;
    send_req(1'b0, 32'h0000_1000, 8'd3);
    ar_hs;
    for (int i = 0; i < 20 && beat < 4; i++) begin
      rd_ready = ~i[0];
      axi.rvalid = 1'b1; axi.rresp = 2'b00; axi.rdata = beat; axi.rlast = (beat == 3); #1;
      tests++; if (axi.rready !== rd_ready) begin fails++; $display("FAIL bp_rready_mirror: got %b want %b", axi.rready, rd_ready); end
      if (rd_valid && rd_ready) begin
        tests++; if ({rd_data, rd_last} !== {beat[31:0], beat == 3}) begin
          fails++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", beat, rd_data, rd_last, beat, beat == 3);
        end
        beat++;
      end
      step;
    end
    #1;
    tests++; if (beat !== 4) begin fails++; $display("FAIL bp_beat_count: got %0d want 4", beat); end
    tests++; if ({resp_valid, resp_err, rd_valid} !== 3'b100) begin fails++; $display("FAIL bp_resp: got %b want 100", {resp_valid, resp_err, rd_valid}); end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_write_gaps;
    int beat = 0;
    send_req(1'b1, 32'h0000_2000, 8'd3);
    wd_valid = 1'b1; wd_data = 32'h0BAD; wd_strb = 4'hF; axi.wready = 1'b1; #1;
    tests++; if ({axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid} !== {1'b1, 32'h2000, 8'd3, 3'd2, 2'b01, 4'd0}) begin
      fails++; $display("FAIL wr_aw_fields: got %h want %h", {axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid}, {1'b1, 32'h2000, 8'd3, 3'd2, 2'b01, 4'd0});
    end
    tests++; if ({axi.wvalid, wd_ready} !== 2'b00) begin fails++; $display("FAIL wr_w_before_aw: got %b want 00", {axi.wvalid, wd_ready}); end
    step;
    tests++; if ({axi.awvalid, axi.awaddr, axi.wvalid} !== {1'b1, 32'h2000, 1'b0}) begin
      fails++; $display("FAIL wr_aw_hold: got %h want %h", {axi.awvalid, axi.awaddr, axi.wvalid}, {1'b1, 32'h2000, 1'b0});
    end
    aw_hs;
    for (int i = 0; i < 30 && beat < 4; i++) begin
      wd_valid = (i % 3 == 0); wd_data = 32'hA0 + beat; #1;
      tests++; if (axi.bready !== 1'b0) begin fails++; $display("FAIL wr_bready_in_w: got %b want 0", axi.bready); end
      if (wd_valid) begin
        tests++; if ({axi.wvalid, wd_ready, axi.wdata, axi.wstrb, axi.wlast} !== {1'b1, 1'b1, 32'hA0 + beat, 4'hF, beat == 3}) begin
          fails++; $display("FAIL wr_beat%0d: got %h want %h", beat, {axi.wvalid, wd_ready, axi.wdata, axi.wstrb, axi.wlast}, {1'b1, 1'b1, 32'hA0 + beat, 4'hF, beat == 3});
        end
        beat++;
      end else begin
        tests++; if (axi.wvalid !== 1'b0) begin fails++; $display("FAIL wr_gap_wvalid: got %b want 0", axi.wvalid); end
      end
      step;
    end
    wd_valid = 1'b0; #1;
    tests++; if (beat !== 4) begin fails++; $display("FAIL wr_beat_count: got %0d want 4", beat); end
    tests++; if ({axi.bready, resp_valid} !== 2'b10) begin fails++; $display("FAIL wr_b_wait: got %b want 10", {axi.bready, resp_valid}); end
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    step;
    axi.bvalid = 1'b0; #1;
    tests++; if ({resp_valid, resp_err, axi.bready} !== 3'b100) begin fails++; $display("FAIL wr_resp: got %b want 100", {resp_valid, resp_err, axi.bready}); end
    axi.wready = 1'b0;
  endtask

  task automatic test_write_error;
    send_req(1'b1, 32'h0000_3000, 8'd0);
    aw_hs;
    wd_valid = 1'b1; wd_data = 32'h1; axi.wready = 1'b1; #1;
    tests++; if (axi.wlast !== 1'b1) begin fails++; $display("FAIL werr_wlast: got %b want 1", axi.wlast); end
    step;
    wd_valid = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b10;
    step;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; #1;
    tests++; if ({resp_valid, resp_err} !== 2'b11) begin fails++; $display("FAIL werr_resp: got %b want 11", {resp_valid, resp_err}); end
  endtask

  task automatic test_early_rlast;
    send_req(1'b0, 32'h0000_4000, 8'd3);
    ar_hs;
    rd_ready = 1'b1; axi.rvalid = 1'b1; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rdata = 32'h10;
    step;
    axi.rlast = 1'b1; axi.rdata = 32'h11; #1;
    tests++; if ({rd_valid, rd_last, rd_data} !== {1'b1, 1'b1, 32'h11}) begin fails++; $display("FAIL early_beat1: got %h want %h", {rd_valid, rd_last, rd_data}, {1'b1, 1'b1, 32'h11}); end
    step;
    tests++; if ({resp_valid, resp_err, req_ready, rd_valid} !== 4'b1110) begin fails++; $display("FAIL early_resp: got %b want 1110", {resp_valid, resp_err, req_ready, rd_valid}); end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    logic seen = 1'b0;
    send_req(1'b1, 32'h0000_5000, 8'd3);
    aw_hs;
    wd_valid = 1'b1; axi.wready = 1'b1;
    step; step;
    rst = 1'b1;
    step;
    tests++; if ({axi.arvalid, axi.awvalid, axi.wvalid, wd_ready, axi.rready, rd_valid, axi.bready, resp_valid, req_ready} !== 9'b0) begin
      fails++; $display("FAIL rstmid_outputs: got %b want 0", {axi.arvalid, axi.awvalid, axi.wvalid, wd_ready, axi.rready, rd_valid, axi.bready, resp_valid, req_ready});
    end
    rst = 1'b0; wd_valid = 1'b0; axi.wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen = 1'b1;
      step;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_no_resp: got %b want 0", seen); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_idle: got %b want 1", req_ready); end
    send_req(1'b0, 32'h0000_6000, 8'd0);
    ar_hs;
    axi.rvalid = 1'b1; axi.rdata = 32'h1234_5678; axi.rlast = 1'b1; rd_ready = 1'b1; #1;
    tests++; if ({rd_valid, rd_data, rd_last} !== {1'b1, 32'h1234_5678, 1'b1}) begin fails++; $display("FAIL rstmid_read_beat: got %h want %h", {rd_valid, rd_data, rd_last}, {1'b1, 32'h1234_5678, 1'b1}); end
    step;
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_ready = 1'b0; #1;
    tests++; if ({resp_valid, resp_err} !== 2'b10) begin fails++; $display("FAIL rstmid_read_resp: got %b want 10", {resp_valid, resp_err}); end
  endtask

  task automatic test_back_to_back;
    send_req(1'b0, 32'h0000_7000, 8'd0);
    ar_hs;
    axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h77; rd_ready = 1'b1;
    step;
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_8000; req_len = 8'd0; #1;
    tests++; if ({resp_valid, req_ready} !== 2'b11) begin fails++; $display("FAIL b2b_accept: got %b want 11", {resp_valid, req_ready}); end
    step;
    req_valid = 1'b0; #1;
    tests++; if ({axi.awvalid, axi.awaddr} !== {1'b1, 32'h8000}) begin fails++; $display("FAIL b2b_aw: got %h want %h", {axi.awvalid, axi.awaddr}, {1'b1, 32'h8000}); end
    aw_hs;
    wd_valid = 1'b1; axi.wready = 1'b1;
    step;
    wd_valid = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b00;
    step;
    axi.bvalid = 1'b0; #1;
    tests++; if ({resp_valid, resp_err} !== 2'b10) begin fails++; $display("FAIL b2b_write_resp: got %b want 10", {resp_valid, resp_err}); end
  endtask

  task automatic test_long_write;
    send_req(1'b1, 32'h0000_9000, 8'd255);
    aw_hs;
    wd_valid = 1'b1; axi.wready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wd_data = i; #1;
      tests++; if ({axi.wvalid, axi.wlast} !== {1'b1, i == 255}) begin fails++; $display("FAIL long_beat%0d: got %b want %b", i, {axi.wvalid, axi.wlast}, {1'b1, i == 255}); end
      step;
    end
    wd_valid = 1'b0; axi.wready = 1'b0; #1;
    tests++; if (axi.bready !== 1'b1) begin fails++; $display("FAIL long_in_b: got %b want 1", axi.bready); end
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    step;
    axi.bvalid = 1'b0; #1;
    tests++; if ({resp_valid, resp_err} !== 2'b10) begin fails++; $display("FAIL long_resp: got %b want 10", {resp_valid, resp_err}); end
  endtask

  initial begin
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'd0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0; axi.rlast = 1'b0; axi.rid = 4'd0;
    test_reset;
    test_single_read;
    test_read_backpressure;
    test_write_gaps;
    test_write_error;
    test_early_rlast;
    test_reset_mid_write;
    test_back_to_back;
    test_long_write;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
